// File: rtl/matrix_win3x3_gen_pkg.sv
// matrix_win3x3_gen_pkg: shared constants and FSM encoding for the 3x3 window generator
package matrix_win3x3_gen_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int WIN_TAPS = 9;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/matrix_win3x3_gen_line_buf.sv
// matrix_win3x3_gen_line_buf: two line buffers packed per word, synchronous read returning old data
module matrix_win3x3_gen_line_buf #(
  parameter int IMG_W = 416,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] waddr,
  input  logic [2*PIX_W-1:0]       wdata,
  input  logic                     re,
  input  logic [$clog2(IMG_W)-1:0] raddr,
  output logic [2*PIX_W-1:0]       rdata
);
  logic [2*PIX_W-1:0] mem [IMG_W];
  // write new {lb0,pix}; registered read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/matrix_win3x3_gen.sv
// matrix_win3x3_gen: pops raster pixels from a FIFO and emits valid-mode 3x3 windows
module matrix_win3x3_gen
  import matrix_win3x3_gen_pkg::*;
#(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  output logic                        rd_en,
  input  logic [PIX_W-1:0]            rd_data,
  input  logic                        rd_empty,
  output logic [WIN_TAPS*PIX_W-1:0]   win_data,
  output logic                        win_valid,
  output logic [$clog2(IMG_H)-1:0]    win_row,
  output logic [$clog2(IMG_W)-1:0]    win_col,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int IW = $clog2(TOTAL + 1);
  state_t state, state_nx;
  logic [IW-1:0] issued;
  logic [CW-1:0] col, rd_col;
  logic [RW-1:0] row;
  logic pix_vld, in_win;
  logic [PIX_W-1:0] w [3][3];
  logic [2*PIX_W-1:0] lb_q;
  assign rd_en = (state == ST_RUN) && !rd_empty && (issued < IW'(TOTAL));
  assign busy = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign in_win = pix_vld && (row >= RW'(2)) && (col >= CW'(2));
  assign win_data = {w[0][0], w[0][1], w[0][2], w[1][0], w[1][1], w[1][2], w[2][0], w[2][1], w[2][2]};
  // next state: DRAIN waits for the final in-flight pixel to be shifted in
  always_comb begin
    state_nx = state;
    state_nx = (state == ST_IDLE && frame_start) ? ST_RUN :
               (state == ST_RUN && issued == IW'(TOTAL)) ? ST_DRAIN :
               (state == ST_DRAIN && !pix_vld) ? ST_DONE :
               (state == ST_DONE) ? ST_IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  // pop/read-address counters run at rd_en, write position counters at pix_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_vld <= 1'b0;
      issued <= '0;
      rd_col <= '0;
      col <= '0;
      row <= '0;
    end else begin
      pix_vld <= rd_en;
      if (state == ST_IDLE && frame_start) begin
        issued <= '0;
        rd_col <= '0;
        col <= '0;
        row <= '0;
      end
      if (rd_en) begin
        issued <= issued + IW'(1);
        rd_col <= (rd_col == CW'(IMG_W - 1)) ? '0 : rd_col + CW'(1);
      end
      if (pix_vld) begin
        col <= (col == CW'(IMG_W - 1)) ? '0 : col + CW'(1);
        row <= (col != CW'(IMG_W - 1)) ? row : (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end
    end
  end
  // shift window left and register the output qualifiers
  always_ff @(posedge clk) begin
    if (rst) begin
      w <= '{default: '0};
      win_valid <= 1'b0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      win_valid <= in_win;
      if (pix_vld) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            w[r][c] <= w[r][c+1];
        w[0][2] <= lb_q[2*PIX_W-1:PIX_W];
        w[1][2] <= lb_q[PIX_W-1:0];
        w[2][2] <= rd_data;
      end
      if (in_win) begin
        win_row <= row - RW'(1);
        win_col <= col - CW'(1);
      end
    end
  end
  matrix_win3x3_gen_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
    .clk  (clk),
    .we   (pix_vld),
    .waddr(col),
    .wdata({lb_q[PIX_W-1:0], rd_data}),
    .re   (rd_en),
    .raddr(rd_col),
    .rdata(lb_q)
  );
endmodule

// File: tb/tb_matrix_win3x3_gen.sv
// tb_matrix_win3x3_gen: randomized FIFO stimulus with a scoreboard of expected 3x3 windows
module tb_matrix_win3x3_gen;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  typedef struct {
    logic [71:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
  } win_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic rd_en, rd_empty = 1'b1;
  logic [7:0] rd_data = '0;
  logic [71:0] win_data;
  logic win_valid, busy, frame_done;
  logic [2:0] win_row, win_col;
  logic [7:0] fifo [$];
  win_t exp_q [$];
  logic [7:0] pix [N];
  logic force_ne = 1'b0, rand_mode = 1'b0, mask = 1'b0, pop_s = 1'b0, prev_valid = 1'b0;
  logic [71:0] first_win = '0;
  int tests = 0, fails = 0, win_cnt = 0, done_cnt = 0, pops = 0, viol = 0;

  matrix_win3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .win_data(win_data), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: data appears the cycle after a pop; emptiness optionally masked at random
  always @(posedge clk) begin
    pop_s = rd_en;
    #1;
    if (pop_s && fifo.size() > 0) rd_data = fifo.pop_front();
    mask = rand_mode && ($urandom_range(0, 1) == 1);
    rd_empty = !force_ne && (fifo.size() == 0 || mask);
  end

  // monitor: compare each presented window against the scoreboard
  always @(negedge clk) begin
    if (rst) prev_valid = 1'b0;
    else begin
      if (rd_en) pops++;
      if (rd_en && rd_empty) viol++;
      if (win_valid) begin
        if (exp_q.size() == 0) chk("win_extra", 72'd1, 72'd0);
        else begin
          win_t e;
          e = exp_q.pop_front();
          chk("win_data", win_data, e.d);
          chk("win_row", 72'(win_row), 72'(e.r));
          chk("win_col", 72'(win_col), 72'(e.c));
        end
        if (win_cnt == 0) first_win = win_data;
        win_cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_after_last", {70'd0, prev_valid, exp_q.size() == 0}, 72'd3);
      end
      prev_valid = win_valid;
    end
  end

  // fill the FIFO and derive every expected window directly from the image
  task automatic load_frame(input int base, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      v = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
      fifo.push_back(v);
      if (i < N) pix[i] = v;
    end
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        win_t e;
        e.d = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.d = {e.d[63:0], pix[(r - 2 + i) * W + (c - 2 + j)]};
        e.r = 3'(r - 1);
        e.c = 3'(c - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic pulse_start();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      ok = (done_cnt > d0);
    end
    chk("frame_done_timeout", 72'(ok), 72'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 72'(rd_en), 72'd0);
    chk({tag, "_win_valid"}, 72'(win_valid), 72'd0);
    chk({tag, "_win_data"}, win_data, 72'd0);
    chk({tag, "_win_row"}, 72'(win_row), 72'd0);
    chk({tag, "_win_col"}, 72'(win_col), 72'd0);
    chk({tag, "_busy"}, 72'(busy), 72'd0);
    chk({tag, "_frame_done"}, 72'(frame_done), 72'd0);
  endtask

  initial begin
    force_ne = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    force_ne = 1'b0;
    repeat (2) @(negedge clk);

    win_cnt = 0; done_cnt = 0; pops = 0;
    load_frame(0, N, 0);
    pulse_start();
    wait_done();
    chk("t2_win_count", 72'(win_cnt), 72'd24);
    chk("t2_done_count", 72'(done_cnt), 72'd1);
    chk("t2_first_win", first_win, {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18});
    chk("t2_busy_after", 72'(busy), 72'd0);

    win_cnt = 0; done_cnt = 0; pops = 0; rand_mode = 1'b1;
    load_frame(0, N, 1);
    pulse_start();
    wait_done();
    rand_mode = 1'b0;
    chk("t3_win_count", 72'(win_cnt), 72'd24);
    chk("t3_pops", 72'(pops), 72'(N));

    win_cnt = 0; done_cnt = 0; pops = 0;
    load_frame(0, 60, 1);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done();
    repeat (20) @(negedge clk);
    chk("t4_pops", 72'(pops), 72'd48);
    chk("t4_win_count", 72'(win_cnt), 72'd24);
    chk("t4_fifo_left", 72'(fifo.size()), 72'd12);
    chk("t4_busy_after", 72'(busy), 72'd0);
    fifo.delete();

    win_cnt = 0; done_cnt = 0; pops = 0;
    load_frame(0, N, 1);
    pulse_start();
    for (int k = 0; k < 500 && pops < 20; k++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    exp_q.delete();
    fifo.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    win_cnt = 0; done_cnt = 0;
    load_frame(100, N, 0);
    pulse_start();
    wait_done();
    chk("t5_win_count", 72'(win_cnt), 72'd24);
    chk("t5_first_win", first_win, {8'd100, 8'd101, 8'd102, 8'd108, 8'd109, 8'd110, 8'd116, 8'd117, 8'd118});
    chk("rd_en_while_empty", 72'(viol), 72'd0);
    chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
